// File: rtl/id_stage_pipe_pkg.sv
// Shared types and helpers for the RV32I decode stage: writeback mux selects,
// opcodes, the ID/EX record, immediate generation and load alignment.
package regfilemux;

   typedef enum logic [3:0] {
      alu_out  = 4'd0,
      br_en    = 4'd1,
      u_imm    = 4'd2,
      lw       = 4'd3,
      pc_plus4 = 4'd4,
      lb       = 4'd5,
      lbu      = 4'd6,
      lh       = 4'd7,
      lhu      = 4'd8
   } regfilemux_sel_t;

endpackage : regfilemux

package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_t;

   // Per-cycle action of the ID/EX register, in priority order.
   typedef enum logic [2:0] {
      ACT_RESET,
      ACT_FLUSH,
      ACT_HOLD,
      ACT_BUBBLE,
      ACT_ISSUE
   } id_action_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
   } id_ex_t;

   function automatic imm_type_t imm_type_of(input logic [6:0] opc);
      case (opc)
         op_load, op_imm, op_jalr: return IMM_I;
         op_store:                 return IMM_S;
         op_br:                    return IMM_B;
         op_lui, op_auipc:         return IMM_U;
         op_jal:                   return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:0] instr);
      case (imm_type_of(instr[6:0]))
         IMM_I:   return {{21{instr[31]}}, instr[30:20]};
         IMM_S:   return {{21{instr[31]}}, instr[30:25], instr[11:7]};
         IMM_B:   return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   return {instr[31:12], 12'h000};
         IMM_J:   return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

   // Byte loads pick the lane named by lo; half loads use lo[1] only.
   function automatic logic [31:0] load_align(input regfilemux::regfilemux_sel_t sel,
                                              input logic [31:0] rdata,
                                              input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{lo, 3'b000} +: 8];
      h = lo[1] ? rdata[31:16] : rdata[15:0];
      case (sel)
         regfilemux::lb:  return {{24{b[7]}}, b};
         regfilemux::lbu: return {24'h000000, b};
         regfilemux::lh:  return {{16{h[15]}}, h};
         regfilemux::lhu: return {16'h0000, h};
         default:         return rdata;
      endcase
   endfunction

endpackage : rv32i_types

// File: rtl/id_stage_pipe_regfile.sv
// Two-read one-write register file with x0 tied to zero and optional
// write-through forwarding of the same-cycle write to both read ports.
module regfile_bypass
#(
   parameter int unsigned NREGS  = 32,
   parameter int unsigned XLEN   = 32,
   parameter bit          BYPASS = 1'b1,
   parameter int unsigned AW     = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs [NREGS];

   // Register storage: cleared on reset, writes to x0 dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read port 1: x0 is zero, otherwise forward a matching write or read storage.
   always_comb begin
      rdata1 = '0;
      if (raddr1 != '0) begin
         if (BYPASS && we && (raddr1 == waddr)) rdata1 = wdata;
         else                                   rdata1 = regs[raddr1];
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      rdata2 = '0;
      if (raddr2 != '0) begin
         if (BYPASS && we && (raddr2 == waddr)) rdata2 = wdata;
         else                                   rdata2 = regs[raddr2];
      end
   end

endmodule : regfile_bypass

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file with writeback mux, immediate generation,
// load-use stall and a registered ID/EX stage with valid/ready and flush.
module id_stage_pipe
   import rv32i_types::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NREGS     = 32,
   parameter bit          BYPASS    = 1'b1,
   parameter bit          HAZARD_EN = 1'b1,
   parameter int unsigned AW        = $clog2(NREGS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            if_valid,
   output logic                            if_ready,
   input  logic [XLEN-1:0]                 if_pc,
   input  logic [31:0]                     if_instr,
   input  logic                            flush,
   input  logic                            ex_ready,
   input  logic                            ex_is_load,
   input  logic [AW-1:0]                   ex_rd,
   output logic                            id_valid,
   output logic [XLEN-1:0]                 id_pc,
   output logic [6:0]                      id_opcode,
   output logic [2:0]                      id_funct3,
   output logic [6:0]                      id_funct7,
   output logic [AW-1:0]                   id_rs1,
   output logic [AW-1:0]                   id_rs2,
   output logic [AW-1:0]                   id_rd,
   output logic [XLEN-1:0]                 id_rs1_data,
   output logic [XLEN-1:0]                 id_rs2_data,
   output logic [XLEN-1:0]                 id_imm,
   input  logic                            wb_valid,
   input  logic [AW-1:0]                   wb_rd,
   input  regfilemux::regfilemux_sel_t     wb_sel,
   input  logic [XLEN-1:0]                 wb_alu,
   input  logic [XLEN-1:0]                 wb_u_imm,
   input  logic [XLEN-1:0]                 wb_pc,
   input  logic [XLEN-1:0]                 wb_mem_rdata,
   input  logic                            wb_br_en,
   input  logic [1:0]                      wb_addr_lo
);

   logic [6:0]      opc;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            hazard;
   logic            advance;
   id_action_t      action;
   id_ex_t          dec;
   id_ex_t          id_q;

   assign opc = if_instr[6:0];
   assign rs1 = AW'(if_instr[19:15]);
   assign rs2 = AW'(if_instr[24:20]);
   assign rd  = AW'(if_instr[11:7]);

   // Writeback value selection, including load byte/half alignment.
   always_comb begin
      wb_data = '0;
      case (wb_sel)
         regfilemux::alu_out:  wb_data = wb_alu;
         regfilemux::br_en:    wb_data = XLEN'(wb_br_en);
         regfilemux::u_imm:    wb_data = wb_u_imm;
         regfilemux::pc_plus4: wb_data = wb_pc + XLEN'(4);
         default:              wb_data = XLEN'(load_align(wb_sel, 32'(wb_mem_rdata), wb_addr_lo));
      endcase
   end

   regfile_bypass #(
      .NREGS  (NREGS),
      .XLEN   (XLEN),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_valid),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // Source-operand usage by opcode for hazard detection.
   always_comb begin
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      case (opc)
         op_lui, op_auipc, op_jal: uses_rs1 = 1'b0;
         default:                  uses_rs1 = 1'b1;
      endcase
      case (opc)
         op_br, op_store, op_reg: uses_rs2 = 1'b1;
         default:                 uses_rs2 = 1'b0;
      endcase
   end

   // ex_rd/ex_is_load describe the ID/EX occupant, so the stall needs id_valid.
   assign hazard = HAZARD_EN && if_valid && id_valid && ex_is_load && (ex_rd != '0) &&
                   ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
   assign advance = ex_ready || !id_valid;

   // Pick this cycle's ID/EX action: rst > flush > hold > bubble > issue.
   always_comb begin
      action = ACT_ISSUE;
      if (rst)           action = ACT_RESET;
      else if (flush)    action = ACT_FLUSH;
      else if (!advance) action = ACT_HOLD;
      else if (hazard)   action = ACT_BUBBLE;
   end

   assign if_ready = (action == ACT_FLUSH) || (action == ACT_ISSUE);

   // Decoded record of the instruction currently in IF/ID.
   always_comb begin
      dec          = '0;
      dec.pc       = 32'(if_pc);
      dec.opcode   = opc;
      dec.funct3   = if_instr[14:12];
      dec.funct7   = if_instr[31:25];
      dec.rs1      = 5'(rs1);
      dec.rs2      = 5'(rs2);
      dec.rd       = 5'(rd);
      dec.rs1_data = 32'(rf_rdata1);
      dec.rs2_data = 32'(rf_rdata2);
      dec.imm      = imm_gen(if_instr);
   end

   // ID/EX register update according to the selected action.
   always_ff @(posedge clk) begin
      case (action)
         ACT_RESET: begin
            id_q     <= '0;
            id_valid <= 1'b0;
         end
         ACT_FLUSH, ACT_BUBBLE: begin
            id_valid <= 1'b0;
         end
         ACT_HOLD: begin
            id_valid <= id_valid;
         end
         default: begin
            id_q     <= dec;
            id_valid <= if_valid;
         end
      endcase
   end

   assign id_pc       = XLEN'(id_q.pc);
   assign id_opcode   = id_q.opcode;
   assign id_funct3   = id_q.funct3;
   assign id_funct7   = id_q.funct7;
   assign id_rs1      = AW'(id_q.rs1);
   assign id_rs2      = AW'(id_q.rs2);
   assign id_rd       = AW'(id_q.rd);
   assign id_rs1_data = XLEN'(id_q.rs1_data);
   assign id_rs2_data = XLEN'(id_q.rs2_data);
   assign id_imm      = XLEN'(id_q.imm);

endmodule : id_stage_pipe
